generador_estimulo_tx: RTL and testbench

Synthesizable, parametrised stimulus generator and lane checker for the PHY transmit path. It drives `active`, `valid` and `data_input` into the TX DUT from a selectable data pattern, and replaces the fixed hand-written stimulus sequence. It also compares the per-lane outputs of the behavioural and synthesized TX instances cycle by cycle. It sits beside the two TX instances in the bench top and runs on the word clock `clk_2f`.

---
 rtl/generador_estimulo_tx.sv | 159 +++++++++++++++
 tb/tb_generador_estimulo_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/generador_estimulo_tx.sv
// rtl/generador_estimulo_tx.sv - TX stimulus generator with per-lane output checker
// Optional checker built only when GENERADOR_CHECKER_EN is defined.
module generador_estimulo_tx #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          LANES        = 2,
    parameter int          LANE_WIDTH   = 8,
    parameter int          NUM_WORDS    = 8,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] SEED         = 32'hFFFFEEEE,
    parameter logic [31:0] TAPS         = 32'h80200003,
    parameter int          CNT_WIDTH    = 8
) (
    input  logic                          clk_2f,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [3:0]                    valid_pattern,
    input  logic [LANES*LANE_WIDTH-1:0]   data_out_ps,
    input  logic [LANES*LANE_WIDTH-1:0]   data_out_ps_sintetizado,
    output logic                          active,
    output logic                          valid,
    output logic [DATA_WIDTH-1:0]         data_input,
    output logic                          busy,
    output logic                          done,
    output logic [LANES-1:0]              lane_err,
    output logic                          err,
    output logic [CNT_WIDTH-1:0]          err_count
);

    localparam int K_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(NUM_WORDS - 1);
    localparam logic [D_W-1:0] LAST_D = D_W'(DRAIN_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] TAPS_W    = DATA_WIDTH'(TAPS);
    localparam logic [DATA_WIDTH-1:0] LFSR_INIT = (SEED_W == '0) ? DATA_WIDTH'(1) : SEED_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [1:0]      mode_q;
    logic [3:0]      vp_q;
    logic [K_W-1:0]  k;
    logic [1:0]      vidx;
    logic [D_W-1:0]  dcnt;

    function automatic logic [DATA_WIDTH-1:0] first_word(input logic [1:0] m);
        case (m)
            2'b01:   return LFSR_INIT;
            2'b11:   return DATA_WIDTH'(1);
            default: return SEED_W;
        endcase
    endfunction

    // Walking-one is a rotate so the index wraps modulo DATA_WIDTH for free.
    function automatic logic [DATA_WIDTH-1:0] next_word(input logic [1:0] m,
                                                        input logic [DATA_WIDTH-1:0] w);
        case (m)
            2'b00:   return w + DATA_WIDTH'(1);
            2'b01:   return (w >> 1) ^ (w[0] ? TAPS_W : '0);
            2'b10:   return w;
            default: return {w[DATA_WIDTH-2:0], w[DATA_WIDTH-1]};
        endcase
    endfunction

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= '0;
            vp_q       <= '0;
            k          <= '0;
            vidx       <= '0;
            dcnt       <= '0;
            active     <= 1'b0;
            valid      <= 1'b0;
            data_input <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        mode_q     <= mode;
                        vp_q       <= valid_pattern;
                        k          <= '0;
                        vidx       <= 2'd1;
                        active     <= 1'b1;
                        valid      <= valid_pattern[0];
                        data_input <= first_word(mode);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (k == LAST_K) begin
                        state      <= DRAIN;
                        dcnt       <= '0;
                        active     <= 1'b0;
                        valid      <= 1'b0;
                        data_input <= '0;
                    end else begin
                        k          <= k + K_W'(1);
                        vidx       <= vidx + 2'd1;
                        valid      <= vp_q[vidx];
                        data_input <= next_word(mode_q, data_input);
                    end
                end
                DRAIN: begin
                    if (dcnt == LAST_D) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + D_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GENERADOR_CHECKER_EN
    logic [LANES-1:0]     diff;
    logic [LANES-1:0]     lane_err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    for (genvar i = 0; i < LANES; i++) begin : g_cmp
        assign diff[i] = data_out_ps[i*LANE_WIDTH +: LANE_WIDTH] !=
                         data_out_ps_sintetizado[i*LANE_WIDTH +: LANE_WIDTH];
    end

    // Comparing in DRAIN too means the sample on the edge leaving DRAIN still counts.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            lane_err_q <= '0;
            cnt_q      <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            lane_err_q <= '0;
            cnt_q      <= '0;
        end else if (state == RUN || state == DRAIN) begin
            lane_err_q <= lane_err_q | diff;
            if (|diff && cnt_q != '1)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign lane_err  = lane_err_q;
    assign err_count = cnt_q;
`else
    logic unused_lanes;
    assign unused_lanes = ^{data_out_ps, data_out_ps_sintetizado};
    assign lane_err     = '0;
    assign err_count    = '0;
`endif

    assign err = |lane_err;

endmodule

// File: tb/tb_generador_estimulo_tx.sv
// tb/tb_generador_estimulo_tx.sv - randomized bench against a behavioural word/error model
module tb_generador_estimulo_tx;

`ifdef GENERADOR_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [1:0]  mode;
    logic [3:0]  vp;
    logic [15:0] ps, ss;

    logic        act0, val0, busy0, done0, err0;
    logic        act1, val1, busy1, done1, err1;
    logic [31:0] data0, data1;
    logic [1:0]  lerr0, lerr1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    int cur = 0;
    int total = 0;
    int bad = 0;

    logic        o_act, o_val, o_busy, o_done, o_err;
    logic [31:0] o_data;
    logic [1:0]  o_lerr;
    logic [7:0]  o_cnt;

    assign o_act  = cur != 0 ? act1  : act0;
    assign o_val  = cur != 0 ? val1  : val0;
    assign o_busy = cur != 0 ? busy1 : busy0;
    assign o_done = cur != 0 ? done1 : done0;
    assign o_err  = cur != 0 ? err1  : err0;
    assign o_data = cur != 0 ? data1 : data0;
    assign o_lerr = cur != 0 ? lerr1 : lerr0;
    assign o_cnt  = cur != 0 ? {6'b0, cnt1} : cnt0;

    always #5 clk_2f = ~clk_2f;

    generador_estimulo_tx #(
        .NUM_WORDS(4), .DRAIN_CYCLES(4), .SEED(32'hFFFFFFFE), .CNT_WIDTH(8)
    ) dut0 (
        .clk_2f(clk_2f), .reset(reset), .start(start0), .mode(mode), .valid_pattern(vp),
        .data_out_ps(ps), .data_out_ps_sintetizado(ss),
        .active(act0), .valid(val0), .data_input(data0), .busy(busy0), .done(done0),
        .lane_err(lerr0), .err(err0), .err_count(cnt0)
    );

    generador_estimulo_tx #(
        .NUM_WORDS(8), .DRAIN_CYCLES(4), .SEED(32'h00000001), .CNT_WIDTH(2)
    ) dut1 (
        .clk_2f(clk_2f), .reset(reset), .start(start1), .mode(mode), .valid_pattern(vp),
        .data_out_ps(ps), .data_out_ps_sintetizado(ss),
        .active(act1), .valid(val1), .data_input(data1), .busy(busy1), .done(done1),
        .lane_err(lerr1), .err(err1), .err_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] m, input logic [31:0] seed,
                                               input int k);
        logic [31:0] w;
        case (m)
            2'b00: return seed + 32'(k);
            2'b01: begin
                w = (seed == 0) ? 32'h1 : seed;
                for (int j = 0; j < k; j++) w = (w >> 1) ^ (w[0] ? TAPS : 32'h0);
                return w;
            end
            2'b10: return seed;
            default: return 32'h1 << (k % 32);
        endcase
    endfunction

    // emode: 0 clean, 1 one-bit flip on lane 1 at slot 1, 2 mismatch every slot, 3 random
    task automatic run(input int sel, input logic [1:0] m, input logic [3:0] vpat,
                       input int emode, input int abort_slot);
        int nw, dc, cmax, cnt;
        logic [31:0] seed;
        logic [1:0]  lerr;
        logic [15:0] msk;
        nw   = sel != 0 ? 8 : 4;
        dc   = 4;
        cmax = sel != 0 ? 3 : 255;
        seed = sel != 0 ? 32'h1 : 32'hFFFFFFFE;
        cnt  = 0;
        lerr = 2'b00;
        cur  = sel;
        mode = m;
        vp   = vpat;
        ps   = 16'($urandom);
        ss   = ps;
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk_2f);
        @(negedge clk_2f);
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 2'($urandom);
        vp     = 4'($urandom);
        for (int i = 0; i <= nw + dc; i++) begin
            check("active", 32'(o_act), 32'(i < nw));
            check("valid", 32'(o_val), i < nw ? 32'(vpat[i % 4]) : 32'h0);
            check("data", o_data, i < nw ? model_word(m, seed, i) : 32'h0);
            check("busy", 32'(o_busy), 32'(i < nw + dc));
            check("done", 32'(o_done), 32'(i == nw + dc));
            check("lane_err", 32'(o_lerr), CHK ? 32'(lerr) : 32'h0);
            check("err", 32'(o_err), CHK ? 32'(lerr != 0) : 32'h0);
            check("err_count", 32'(o_cnt), CHK ? 32'(cnt) : 32'h0);
            if (i == abort_slot) begin
                reset = 1'b1;
                #1;
                check("abort_ctrl", 32'({o_act, o_val, o_busy, o_done, o_err, o_lerr, o_cnt}), 32'h0);
                check("abort_data", o_data, 32'h0);
                @(posedge clk_2f);
                @(negedge clk_2f);
                reset = 1'b0;
                return;
            end
            msk = 16'h0;
            if (i < nw + dc) begin
                case (emode)
                    1: if (i == 1) msk = 16'h0100 << ($urandom % 8);
                    2: begin
                        msk = 16'($urandom);
                        if (msk == 16'h0) msk = 16'h0001;
                    end
                    3: if ($urandom % 3 == 0) msk = 16'($urandom);
                    default: msk = 16'h0;
                endcase
            end
            ps = 16'($urandom);
            ss = ps ^ msk;
            if (msk != 16'h0) begin
                lerr = lerr | {|msk[15:8], |msk[7:0]};
                if (cnt < cmax) cnt++;
            end
            @(negedge clk_2f);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 2'b00;
        vp     = 4'h0;
        ps     = 16'h0;
        ss     = 16'h0;
        repeat (2) @(negedge clk_2f);
        cur = 0;
        #1;
        check("reset0", 32'({o_act, o_val, o_busy, o_done, o_err, o_lerr, o_cnt}) | o_data, 32'h0);
        cur = 1;
        #1;
        check("reset1", 32'({o_act, o_val, o_busy, o_done, o_err, o_lerr, o_cnt}) | o_data, 32'h0);
        @(negedge clk_2f);
        reset = 1'b0;
        @(negedge clk_2f);

        run(0, 2'b00, 4'b1111, 0, -1);
        run(1, 2'b01, 4'($urandom), 0, -1);
        run(1, 2'b11, 4'b0011, 0, -1);
        run(0, 2'b10, 4'b1010, 1, -1);
        run(1, 2'($urandom), 4'($urandom), 2, -1);
        run(0, 2'b00, 4'($urandom), 2, 2);
        run(0, 2'b00, 4'($urandom), 0, -1);

        // Start held high in DONE: a new run every NUM_WORDS+DRAIN_CYCLES+1 cycles.
        cur    = 0;
        ps     = 16'h1234;
        ss     = ps;
        start0 = 1'b1;
        @(posedge clk_2f);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_2f);
            check("b2b_busy", 32'(o_busy), 32'((i % 9) < 8));
        end
        start0 = 1'b0;
        @(negedge clk_2f);
        check("b2b_done", 32'(o_done), 32'h1);

        repeat (6) run(int'($urandom % 2), 2'($urandom), 4'($urandom), 3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
